// File: rtl/paillier_result_drain_pkg.sv
// Shared types and width helpers for the Paillier result drain engine.
// Holds the FSM state encoding and the width helpers used by the drain engine and the round-robin picker.
package paillier_drain_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    READ,
    LOAD,
    SEND,
    DONE
  } drain_state_e;

  localparam int DEF_BLOCK_COUNT = 25;
  localparam int DEF_K           = 128;
  localparam int DEF_N           = 32;
  localparam int DEF_DW          = 64;

  // Index width that never collapses to zero bits for a single-entry range.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int beats_per_word(input int k, input int dw);
    return k / dw;
  endfunction

  localparam int DEF_BLK_W  = idx_w(DEF_BLOCK_COUNT);
  localparam int DEF_CNT_W  = $clog2(DEF_N) + 1;
  localparam int DEF_BEAT_W = idx_w(beats_per_word(DEF_K, DEF_DW));

endpackage

// File: rtl/paillier_result_drain_if.sv
// Beat stream from the result drain toward the AXI write path.
interface paillier_result_drain_if #(
  parameter int DW    = 64,
  parameter int BLK_W = 5
) ();
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    out_data;
  logic             out_last;
  logic [BLK_W-1:0] out_blk;

  modport master (
    output out_valid,
    output out_data,
    output out_last,
    output out_blk,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_last,
    input  out_blk,
    output out_ready
  );
endinterface

// File: rtl/paillier_result_drain_rr_pick.sv
// Rotating-priority picker: first eligible index at or after ptr, wrapping to 0.
module paillier_rr_pick
  import paillier_drain_pkg::*;
#(
  parameter  int BLOCK_COUNT = 25,
  localparam int IW          = idx_w(BLOCK_COUNT)
) (
  input  logic [BLOCK_COUNT-1:0] elig,
  input  logic [IW-1:0]          ptr,
  output logic                   found,
  output logic [IW-1:0]          idx
);

  int j;

  // Walk offsets from farthest to nearest so the nearest eligible index overwrites last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int k = BLOCK_COUNT - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= BLOCK_COUNT) j = j - BLOCK_COUNT;
      if (elig[IW'(j)]) begin
        found = 1'b1;
        idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/paillier_result_drain.sv
// Drains complete N-word results from the per-block FIFOs round-robin and serializes them into DW-bit beats.
module paillier_result_drain
  import paillier_drain_pkg::*;
#(
  parameter  int BLOCK_COUNT = 25,
  parameter  int K           = 128,
  parameter  int N           = 32,
  parameter  int DW          = 64,
  localparam int BLK_W       = idx_w(BLOCK_COUNT),
  localparam int CNT_W       = $clog2(N) + 1,
  localparam int BPW         = beats_per_word(K, DW),
  localparam int BEAT_W      = idx_w(BPW)
) (
  input  logic                              M_AXI_ACLK,
  input  logic                              M_AXI_ARESETN,
  input  logic                              start,
  input  logic [63:0]                       total_results,
  output logic                              busy,
  output logic                              done,
  output logic [BLOCK_COUNT-1:0]            rd_rdy,
  input  logic [BLOCK_COUNT-1:0][K-1:0]     rd_dout,
  input  logic [BLOCK_COUNT-1:0][CNT_W-1:0] rd_cnt,
  paillier_result_drain_if.master           out_if
);

  drain_state_e           state;
  logic [63:0]            tot;
  logic [63:0]            res_cnt;
  logic [CNT_W-1:0]       w;
  logic [BEAT_W-1:0]      b;
  logic [BLK_W-1:0]       ptr;
  logic [BLK_W-1:0]       sel;
  logic [BLK_W-1:0]       pick_idx;
  logic                   pick_found;
  logic [BLOCK_COUNT-1:0] elig;
  logic [K-1:0]           word;
  logic                   out_valid_q;
  logic                   hs;
  logic                   beat_end;
  logic                   word_last;

  for (genvar i = 0; i < BLOCK_COUNT; i++) begin : g_elig
    assign elig[i] = (rd_cnt[i] >= CNT_W'(N));
  end

  paillier_rr_pick #(.BLOCK_COUNT(BLOCK_COUNT)) u_pick (
    .elig  (elig),
    .ptr   (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign hs        = out_valid_q && out_if.out_ready;
  assign beat_end  = (b == BEAT_W'(BPW - 1));
  assign word_last = (w == CNT_W'(N - 1));

  // The word register shifts down one beat per handshake, so the low slice is always on the bus.
  assign out_if.out_valid = out_valid_q;
  assign out_if.out_data  = word[DW-1:0];
  assign out_if.out_last  = out_valid_q && beat_end && word_last;
  assign out_if.out_blk   = sel;

  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      rd_rdy      <= '0;
      tot         <= '0;
      res_cnt     <= '0;
      w           <= '0;
      b           <= '0;
      ptr         <= '0;
      sel         <= '0;
      word        <= '0;
      out_valid_q <= 1'b0;
    end else begin
      rd_rdy <= '0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            tot     <= total_results;
            res_cnt <= '0;
            done    <= 1'b0;
            if (total_results == 64'd0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= SCAN;
              busy  <= 1'b1;
            end
          end
        end
        SCAN: begin
          if (pick_found) begin
            sel              <= pick_idx;
            rd_rdy[pick_idx] <= 1'b1;
            state            <= READ;
          end
        end
        // rd_rdy is high during this state; data lands on rd_dout one cycle later.
        READ: state <= LOAD;
        LOAD: begin
          word        <= rd_dout[sel];
          b           <= '0;
          out_valid_q <= 1'b1;
          state       <= SEND;
        end
        SEND: begin
          if (hs) begin
            word <= word >> DW;
            b    <= b + BEAT_W'(1);
            if (beat_end) begin
              out_valid_q <= 1'b0;
              if (!word_last) begin
                w           <= w + CNT_W'(1);
                rd_rdy[sel] <= 1'b1;
                state       <= READ;
              end else begin
                w       <= '0;
                ptr     <= (sel == BLK_W'(BLOCK_COUNT - 1)) ? '0 : sel + BLK_W'(1);
                res_cnt <= res_cnt + 64'd1;
                if (res_cnt + 64'd1 == tot) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                end else begin
                  state <= SCAN;
                end
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_rd_onehot: assert property (@(posedge M_AXI_ACLK) disable iff (!M_AXI_ARESETN)
    $onehot0(rd_rdy));

  a_stall_hold: assert property (@(posedge M_AXI_ACLK) disable iff (!M_AXI_ARESETN)
    (out_if.out_valid && !out_if.out_ready) |=>
      (out_if.out_valid && $stable(out_if.out_data) && $stable(out_if.out_last) && $stable(out_if.out_blk)));

endmodule
